// File: rtl/dds_param_ctrl.sv
// DDS front-panel control: key sync/debounce, field FSM, param edit.
// Ports: clk, rst_n, key_{mode,up,down}_n in; wave_*, edit_field, param_upd out. Option: DDS_AUTOREPEAT_EN.
module dds_param_ctrl #(
  parameter int unsigned DEB_CYCLES    = 1_000_000,
  parameter int unsigned FREQ_INIT     = 1000,
  parameter int unsigned FREQ_MIN      = 100,
  parameter int unsigned FREQ_MAX      = 9999,
`ifdef DDS_AUTOREPEAT_EN
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
`endif
  parameter int unsigned FREQ_STEP     = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode_n,
  input  logic        key_up_n,
  input  logic        key_down_n,
  output logic [1:0]  wave_sel,
  output logic [19:0] wave_freq,
  output logic [1:0]  wave_a,
  output logic [1:0]  edit_field,
  output logic        param_upd
);

  typedef enum logic [1:0] {
    F_WAVE = 2'd0,
    F_FREQ = 2'd1,
    F_AMP  = 2'd2
  } field_t;

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [19:0] FMIN = 20'(FREQ_MIN);
  localparam logic [19:0] FMAX = 20'(FREQ_MAX);
  localparam logic [19:0] FSTP = 20'(FREQ_STEP);
  localparam logic [19:0] FINI = 20'(FREQ_INIT);

  // bit 0 mode, bit 1 up, bit 2 down
  logic [2:0]    raw;
  logic [2:0]    s1, s2, deb, deb_d;
  logic [DW-1:0] cnt [3];
  logic [2:0]    press, ev;

  assign raw = {key_down_n, key_up_n, key_mode_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '1;
      s2    <= '1;
      deb   <= '1;
      deb_d <= '1;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = deb_d & ~deb;

`ifdef DDS_AUTOREPEAT_EN
  localparam int unsigned HMAX =
    (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW = $clog2(HMAX + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

  logic [HW-1:0] hcnt [2];
  logic [1:0]    rep_ph;
  logic [1:0]    rpt;

  // rep_ph=0: waiting out the initial hold; 1: periodic repeat
  always_comb begin
    rpt = '0;
    for (int k = 0; k < 2; k++) begin
      rpt[k] = ~deb[k+1] & ~deb_d[k+1] &
               (rep_ph[k] ? (hcnt[k] == REP_LAST)
                          : (hcnt[k] == HOLD_LAST));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_ph <= '0;
      for (int k = 0; k < 2; k++) hcnt[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (press[k+1] || deb[k+1]) begin
          hcnt[k]   <= '0;
          rep_ph[k] <= 1'b0;
        end else if (rpt[k]) begin
          hcnt[k]   <= '0;
          rep_ph[k] <= 1'b1;
        end else begin
          hcnt[k] <= hcnt[k] + 1'b1;
        end
      end
    end
  end

  assign ev = {press[2] | rpt[1], press[1] | rpt[0], press[0]};
`else
  assign ev = press;
`endif

  field_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [19:0] freq_q, freq_d;
  logic [1:0]  a_q, a_d;
  logic        upd_d;
  logic        inc, dec;

  // mode wins; up with down cancels
  assign inc = ev[1] & ~ev[2] & ~ev[0];
  assign dec = ev[2] & ~ev[1] & ~ev[0];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    freq_d  = freq_q;
    a_d     = a_q;
    unique case (1'b1)
      ev[0]: begin
        case (state_q)
          F_WAVE:  state_d = F_FREQ;
          F_FREQ:  state_d = F_AMP;
          default: state_d = F_WAVE;
        endcase
      end
      inc: begin
        case (state_q)
          F_WAVE: sel_d = sel_q + 2'd1;
          F_FREQ: freq_d = (freq_q >= FMAX - FSTP) ? FMAX
                                                   : freq_q + FSTP;
          default: a_d = (a_q == 2'd3) ? a_q : a_q + 2'd1;
        endcase
      end
      dec: begin
        case (state_q)
          F_WAVE: sel_d = sel_q - 2'd1;
          F_FREQ: freq_d = (freq_q <= FMIN + FSTP) ? FMIN
                                                   : freq_q - FSTP;
          default: a_d = (a_q == 2'd0) ? a_q : a_q - 2'd1;
        endcase
      end
      default: ;
    endcase
    upd_d = (sel_d != sel_q) | (freq_d != freq_q) | (a_d != a_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= F_WAVE;
      sel_q     <= 2'd0;
      freq_q    <= FINI;
      a_q       <= 2'd3;
      param_upd <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      freq_q    <= freq_d;
      a_q       <= a_d;
      param_upd <= upd_d;
    end
  end

  assign wave_sel   = sel_q;
  assign wave_freq  = freq_q;
  assign wave_a     = a_q;
  assign edit_field = state_q;

endmodule
